// File: rtl/eg2000_pkg.sv
// Shared definitions for the palette video output block.
// Holds the display mode encodings, the reference RGB packing widths and
// the default 16-entry colour table loaded into the palette at configuration.
// scale_ch() adapts a 6-bit table channel to another channel width.
package eg2000_pkg;

  // Reference geometry of the default table: 16 entries, 6 bits per channel.
  localparam int DEF_ENTRIES = 16;
  localparam int DEF_BPC     = 6;
  localparam int DEF_RGBW    = 3 * DEF_BPC;

  // Mode bit 1 selects greyscale and bit 0 selects scanlines.
  typedef enum logic [1:0] {
    MODE_NORMAL    = 2'd0,
    MODE_SCAN      = 2'd1,
    MODE_GREY      = 2'd2,
    MODE_GREY_SCAN = 2'd3
  } mode_e;

  // Default palette, packed {R,G,B}; index 15 is the leftmost element.
  localparam logic [DEF_ENTRIES-1:0][DEF_RGBW-1:0] DEFAULT_PAL = {
    18'h38E38,  // 15: R56 G56 B56
    18'h3FFC0,  // 14: R63 G63 B0
    18'h3F03F,  // 13: R63 G0  B63
    18'h3F000,  // 12: R63 G0  B0
    18'h00FFF,  // 11: R0  G63 B63
    18'h00FC0,  // 10: R0  G63 B0
    18'h0003F,  //  9: R0  G0  B63
    18'h14514,  //  8: R20 G20 B20
    18'h28A28,  //  7: R40 G40 B40
    18'h28A00,  //  6: R40 G40 B0
    18'h28E10,  //  5: R40 G56 B16
    18'h28000,  //  4: R40 G0  B0
    18'h00A00,  //  3: R0  G40 B0
    18'h30210,  //  2: R48 G8  B16
    18'h00028,  //  1: R0  G0  B40
    18'h00000   //  0: black
  };

  // Rescale a 6-bit table channel to bpc bits (left shift widens, right shift narrows).
  function automatic int unsigned scale_ch(input int unsigned v6, input int unsigned bpc);
    int unsigned res;
    if (bpc >= 32'(DEF_BPC)) begin
      res = v6 << (bpc - 32'(DEF_BPC));
    end else begin
      res = v6 >> (32'(DEF_BPC) - bpc);
    end
    return res;
  endfunction

endpackage

// File: rtl/palette_ram.sv
// Palette storage: one write port, one synchronous read port.
// Ports:
//   clock  - system clock
//   rst_n  - synchronous active-low reset, clears the read register only
//   we     - write strobe (already qualified by the caller)
//   waddr  - write index, wdata - write value
//   re     - read enable; the read register holds while low
//   raddr  - read index, rdata - registered read value
// On a same-clock write/read of one index the read returns the old entry.
// Contents start from INIT and are never touched by reset.
module palette_ram
  import eg2000_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 18,
  parameter logic [(2**AW)-1:0][DW-1:0] INIT = '0
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DEPTH-1:0][DW-1:0] mem_q = INIT;
  logic [DEPTH-1:0][DW-1:0] mem_d;
  logic [DW-1:0]            rdata_q;
  logic [DW-1:0]            rdata_d;

  // Next-state for storage and read register; reads use mem_q so collisions return old data.
  always_comb begin
    mem_d   = mem_q;
    rdata_d = rdata_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d = mem_q;
    end
    if (!rst_n) begin
      rdata_d = '0;
    end else if (re) begin
      rdata_d = mem_q[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Storage and read register update.
  always_ff @(posedge clock) begin
    mem_q   <= mem_d;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/palette_video.sv
// Palette-based video output stage.
// Looks up a colour index in a writable palette, optionally converts to
// greyscale and/or darkens alternate lines, and delays sync and display
// enable to match. Two pipeline stages, both advancing only on ce_pix.
// Ports:
//   clock    - system clock
//   power    - synchronous active-low reset (run when high)
//   ce_pix   - pixel clock enable
//   pixel    - active display flag
//   color    - palette index
//   hsync    - raw horizontal sync, active high
//   vsync    - raw vertical sync, active high
//   mode     - 0 normal, 1 scanlines, 2 greyscale, 3 greyscale + scanlines
//   pal_we   - palette write strobe, pal_addr / pal_data write index / value
//   rgb      - final colour {R,G,B}
//   sync     - {vsync,hsync} after polarity
//   de       - delayed pixel flag
module palette_video
  import eg2000_pkg::*;
#(
  parameter int   CW   = 4,
  parameter int   BPC  = 6,
  parameter logic HPOL = 1'b0,
  parameter logic VPOL = 1'b0
) (
  input  logic             clock,
  input  logic             power,
  input  logic             ce_pix,
  input  logic             pixel,
  input  logic [CW-1:0]    color,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [1:0]       mode,
  input  logic             pal_we,
  input  logic [CW-1:0]    pal_addr,
  input  logic [3*BPC-1:0] pal_data,
  output logic [3*BPC-1:0] rgb,
  output logic [1:0]       sync,
  output logic             de
);

  localparam int RGBW      = 3 * BPC;
  localparam int PAL_DEPTH = 2 ** CW;

  // Expand the reference table to this instance's depth and channel width.
  function automatic logic [PAL_DEPTH-1:0][RGBW-1:0] build_init();
    logic [PAL_DEPTH-1:0][RGBW-1:0] t;
    logic [DEF_RGBW-1:0]            e;
    t = '0;
    for (int i = 0; i < PAL_DEPTH; i++) begin
      e = DEFAULT_PAL[i % DEF_ENTRIES];
      for (int c = 0; c < 3; c++) begin
        t[i][c*BPC +: BPC] = BPC'(scale_ch(32'(e[c*DEF_BPC +: DEF_BPC]), 32'(BPC)));
      end
    end
    return t;
  endfunction

  localparam logic [PAL_DEPTH-1:0][RGBW-1:0] PAL_INIT = build_init();

  logic [RGBW-1:0] pal_rd;

  // Stage 1 sideband, edge-detect history and line parity.
  logic pix1_q, pix1_d;
  logic hs1_q, hs1_d;
  logic vs1_q, vs1_d;
  logic hs_prev_q, hs_prev_d;
  logic vs_prev_q, vs_prev_d;
  logic par_q, par_d;

  // Stage 2 outputs.
  logic [RGBW-1:0] rgb_q, rgb_d;
  logic [1:0]      sync_q, sync_d;
  logic            de_q, de_d;

  // Colour transform intermediates.
  logic [BPC-1:0]   ch_r, ch_g, ch_b;
  logic [BPC+1:0]   y_sum;
  logic [BPC-1:0]   o_r, o_g, o_b;
  logic             scan_on;

  // Palette writes are blocked while in reset so the table survives untouched.
  palette_ram #(
    .AW   (CW),
    .DW   (RGBW),
    .INIT (PAL_INIT)
  ) u_palette_ram (
    .clock (clock),
    .rst_n (power),
    .we    (pal_we & power),
    .waddr (pal_addr),
    .wdata (pal_data),
    .re    (ce_pix),
    .raddr (color),
    .rdata (pal_rd)
  );

  // Colour transform: greyscale first, then scanline halving, then blanking.
  always_comb begin
    ch_r    = pal_rd[3*BPC-1:2*BPC];
    ch_g    = pal_rd[2*BPC-1:BPC];
    ch_b    = pal_rd[BPC-1:0];
    y_sum   = {2'b00, ch_r} + {1'b0, ch_g, 1'b0} + {2'b00, ch_b};
    o_r     = ch_r;
    o_g     = ch_g;
    o_b     = ch_b;
    scan_on = 1'b0;
    case (mode_e'(mode))
      MODE_NORMAL: begin
        scan_on = 1'b0;
      end
      MODE_SCAN: begin
        scan_on = par_q;
      end
      MODE_GREY: begin
        o_r     = y_sum[BPC+1:2];
        o_g     = y_sum[BPC+1:2];
        o_b     = y_sum[BPC+1:2];
        scan_on = 1'b0;
      end
      MODE_GREY_SCAN: begin
        o_r     = y_sum[BPC+1:2];
        o_g     = y_sum[BPC+1:2];
        o_b     = y_sum[BPC+1:2];
        scan_on = par_q;
      end
      default: begin
        scan_on = 1'b0;
      end
    endcase
    if (scan_on) begin
      o_r = {1'b0, o_r[BPC-1:1]};
      o_g = {1'b0, o_g[BPC-1:1]};
      o_b = {1'b0, o_b[BPC-1:1]};
    end else begin
      o_r = o_r;
      o_g = o_g;
      o_b = o_b;
    end
  end

  // Pipeline and line-parity next-state; everything holds on non-ce_pix clocks.
  always_comb begin
    pix1_d    = pix1_q;
    hs1_d     = hs1_q;
    vs1_d     = vs1_q;
    hs_prev_d = hs_prev_q;
    vs_prev_d = vs_prev_q;
    par_d     = par_q;
    rgb_d     = rgb_q;
    sync_d    = sync_q;
    de_d      = de_q;
    if (!power) begin
      pix1_d    = 1'b0;
      hs1_d     = 1'b0;
      vs1_d     = 1'b0;
      hs_prev_d = 1'b0;
      vs_prev_d = 1'b0;
      par_d     = 1'b0;
      rgb_d     = '0;
      sync_d    = {VPOL, HPOL};
      de_d      = 1'b0;
    end else if (ce_pix) begin
      pix1_d    = pixel;
      hs1_d     = hsync;
      vs1_d     = vsync;
      hs_prev_d = hsync;
      vs_prev_d = vsync;
      // A vsync rise wins over a coincident hsync rise.
      if (vsync && !vs_prev_q) begin
        par_d = 1'b0;
      end else if (hsync && !hs_prev_q) begin
        par_d = ~par_q;
      end else begin
        par_d = par_q;
      end
      rgb_d  = pix1_q ? {o_r, o_g, o_b} : '0;
      sync_d = {vs1_q ^ VPOL, hs1_q ^ HPOL};
      de_d   = pix1_q;
    end else begin
      par_d = par_q;
    end
  end

  // Pipeline register update.
  always_ff @(posedge clock) begin
    pix1_q    <= pix1_d;
    hs1_q     <= hs1_d;
    vs1_q     <= vs1_d;
    hs_prev_q <= hs_prev_d;
    vs_prev_q <= vs_prev_d;
    par_q     <= par_d;
    rgb_q     <= rgb_d;
    sync_q    <= sync_d;
    de_q      <= de_d;
  end

  assign rgb  = rgb_q;
  assign sync = sync_q;
  assign de   = de_q;

endmodule

// File: doc/palette_video.md
PALETTE_VIDEO -- requirements
Module: palette_video

Interface
REQ-001 SHALL have parameter CW, default 4, colour-index width; the palette holds 2**CW entries.
REQ-002 SHALL have parameter BPC, default 6, bits per RGB channel; RGB word width is 3*BPC, packed {R,G,B}.
REQ-003 SHALL have parameter HPOL, default 1'b0, hsync output polarity; 0 passes through, 1 inverts.
REQ-004 SHALL have parameter VPOL, default 1'b0, vsync output polarity; same coding as HPOL.
REQ-005 SHALL have one clock and a synchronous, active-low reset: clock input 1, the single system clock; power input 1, reset when low, run when high.
REQ-006 SHALL have the following ports:
- ce_pix input 1: pixel clock enable.
- pixel input 1: active display, high when visible.
- color input CW: palette index.
- hsync input 1: raw horizontal sync, active high.
- vsync input 1: raw vertical sync, active high.
- mode input 2: 0 normal, 1 scanlines, 2 greyscale, 3 greyscale plus scanlines.
- pal_we input 1: palette write strobe, one clock.
- pal_addr input CW: palette write index.
- pal_data input 3*BPC: palette write value.
- rgb output 3*BPC: final colour.
- sync output 2: {vsync,hsync} after polarity.
- de output 1: delayed pixel.

Function
REQ-007 SHALL advance a 2-stage pipeline only on clocks with ce_pix high; when ce_pix is low, all registers hold.
REQ-008 SHALL register the palette read of color and the sideband (pixel, hsync, vsync) in stage 1, and the colour transform plus outputs in stage 2.
REQ-009 SHALL give rgb, sync and de identical latency: exactly 2 ce_pix-qualified clocks.
REQ-010 SHALL force rgb to 0 when the delayed pixel is 0, whatever the palette contents.
REQ-011 SHALL perform a palette write on any clock with pal_we high, independent of ce_pix.
REQ-012 SHALL return the old entry when a write and a read target the same index on the same clock; the new value is visible from the next read.
REQ-013 SHALL initialise palette contents at configuration from the default table in the package.
REQ-014 SHALL NOT alter palette contents on reset.
REQ-015 SHALL toggle a line-parity bit on each rising edge of the raw hsync, detected on ce_pix clocks.
REQ-016 SHALL clear line parity to 0 on each rising edge of the raw vsync.
REQ-017 SHALL apply only the vsync clear when hsync and vsync rise together.
REQ-018 SHALL, in greyscale modes (2,3), compute Y=(R+2G+B)>>2 at BPC+2 bit width and output {Y,Y,Y}, truncated to BPC bits.
REQ-019 SHALL, in scanline modes (1,3) on lines with parity 1, shift each channel right by 1, applied after greyscale.
REQ-020 SHALL take a mode change effect from the next ce_pix clock; no glitch-free requirement applies mid-line.

Reset
REQ-021 SHALL, while power is low, hold rgb=0, de=0, line parity=0 and all pipeline stages at 0.
REQ-022 SHALL hold sync at {VPOL,HPOL} during reset, i.e. inactive levels.
REQ-023 SHALL ignore palette writes during reset.
REQ-024 SHALL produce first valid output 2 ce_pix clocks after power goes high.

Structure
REQ-025 SHALL place the default 16-entry 18-bit palette table, the mode encodings and the RGB packing widths in package eg2000_pkg.
REQ-026 SHALL implement the palette storage as sub-module palette_ram: 1 write port, 1 synchronous read port, read-old-on-collision, initialised from a parameter table.

Verification
REQ-027 SHALL cover: reset, then mode=0, pixel=1, color=15 -> rgb=0x38E38 exactly 2 ce_pix clocks later; de tracks pixel with the same delay.
REQ-028 SHALL cover: color=2, pixel=0 -> rgb=0 while sync follows the inputs 2 ce_pix clocks later; HPOL=1 inverts sync[0].
REQ-029 SHALL cover: mode=1, color=15, after 1 hsync rise -> rgb=0x1C71C; after a 2nd rise -> 0x38E38; a vsync rise clears parity -> 0x38E38.
REQ-030 SHALL cover: mode=2, color=2 (R48,G8,B16) -> each channel 20, rgb=010100_010100_010100.
REQ-031 SHALL cover: pal_we with pal_addr=5, pal_data=0x3FFFF while reading color=5 on the same clock -> old 18'b101000_111000_010000 is output, then 0x3FFFF on the next read.
REQ-032 SHALL cover: ce_pix held low for 10 clocks mid-line -> rgb, sync and de frozen; power low mid-frame -> outputs 0/inactive next clock and palette contents preserved.
